cell_char_ctrl: RTL and testbench
=================================

Name: cell_char_ctrl

Overview:
- On-die characterization controller for the standard-cell test structures.
- Each measurement target is a ring oscillator built from a chain of one cell type (BUFX2, INVX1, NAND2X1, NOR2X1 chains).
- The block selects one chain, enables it, lets it settle, then counts its oscillations over a programmed gate window.
- It reports a saturating count to the test/scan host through a start/done handshake, and shares the single counter between the chains.

Parameters:
- N_CHAINS, 4, number of ring-oscillator chains (index 0..N_CHAINS-1).
- SEL_W, 2, width of chain select; must satisfy 2**SEL_W >= N_CHAINS.
- CNT_W, 16, edge counter width.
- WIN_W, 16, gate-window length width (in CK cycles).
- SETTLE_CYC, 8, cycles the chain runs before counting starts (min 3, covers synchronizer fill).

Ports:
- CK  in  1  single clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request pulse/level; sampled only in IDLE.
- sel  in  SEL_W  chain index, latched on accepted start.
- win_len  in  WIN_W  gate window length, latched on accepted start.
- ro_in  in  N_CHAINS  raw ring-oscillator taps, asynchronous to CK.
- ro_en  out  N_CHAINS  one-hot chain enable; at most one bit high.
- busy  out  1  high in SETTLE, GATE, DONE.
- done  out  1  one-cycle pulse at measurement end.
- count  out  CNT_W  result, held stable from done until the next accepted start.
- ovf  out  1  count saturated during the last run.
- err  out  1  last request had sel >= N_CHAINS.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE.
  - ro_en=0, busy=0, done=0, count=0, ovf=0, err=0.
  - Synchronizer and edge-detect flops cleared to 0.
  - RST mid-run aborts immediately; ro_en drops in the next cycle.
- States: IDLE, SETTLE, GATE, DONE.
- IDLE:
  - start=1 at edge E0: latch sel and win_len; clear count, ovf, err.
  - If sel >= N_CHAINS: set err=1, go to DONE; ro_en is never asserted.
  - Else if win_len==0: go to DONE (count=0, ro_en never asserted).
  - Else: go to SETTLE and load the down-counter with SETTLE_CYC-1.
- SETTLE:
  - ro_en[sel_q]=1.
  - The synchronizer (2 flops) and the edge-history flop run on ro_in[sel_q]; no counting.
  - Transition to GATE after SETTLE_CYC cycles; load the window counter with win_len-1.
- GATE:
  - ro_en[sel_q] stays 1.
  - Each cycle in which sync_q2=1 and hist=0 (a rising edge) increments count.
  - Count saturates at 2**CNT_W-1; the first increment attempted at max sets ovf=1 (sticky for the run).
  - Lasts exactly win_len cycles, then go to DONE.
- DONE:
  - ro_en=0, done=1 for exactly one cycle, then IDLE.
  - count, ovf and err hold until the next accepted start.
- Latency: done is high in the cycle beginning 1+SETTLE_CYC+win_len edges after E0 for a valid run, and 1 edge after E0 for err or win_len==0.
- start while busy is ignored; there is no queueing.
- The mux selects ro_in[sel_q] only. Unselected taps are ignored, and their X/Z never propagates.
- The edge history persists across the SETTLE to GATE boundary, so no spurious edge is counted in the first GATE cycle.
- Counted frequency is valid only for f_ro < f_CK/2; above that aliasing is expected, and this limit is documented rather than detected.

Optional Feature:
- CELL_CHAR_ACCUM_EN:
  - When defined, an extra input port accum (1 bit) is added and latched at start.
  - If accum_q=1, count and ovf are NOT cleared at an accepted start; the run adds to the previous total, with saturation and ovf sticky across runs.
  - err is always cleared at start.
  - When undefined, the port is absent and count always clears at an accepted start.

Decomposition:
- Package cell_char_pkg contains:
  - State enum cc_state_t {IDLE, SETTLE, GATE, DONE}.
  - Default parameter constants.
  - Function sat_inc(value, max) returning {ovf, next}.
- One sub-module, cell_char_sync: 2-flop synchronizer plus history flop, with synchronous RST, outputting rise_pulse.
- The top level holds the FSM, the down-counters, the mux and the result registers.

Test Plan:
- Reset mid-GATE (sel=1, win_len=100, RST at cycle 50) -> next cycle ro_en=0, busy=0, count=0, no done pulse.
- ro_in[2] toggles every 4 CK (period 8), sel=2, win_len=800 -> done at E0+1+8+800, count=100±1, ro_en=4'b0100 only during SETTLE and GATE.
- win_len=0, sel=0 -> done one cycle after start, count=0, ro_en never high; sel=3'd5 with N_CHAINS=4 and SEL_W=3 -> err=1, done one cycle later.
- CNT_W=4, period-4 ro, win_len=200 -> count=15, ovf=1; the next run with win_len=8 gives count=2, ovf=0.
- Back-to-back starts: start held high through a run -> second run accepted in the cycle after DONE (the IDLE cycle); start pulses during busy are ignored (one done per accepted start).
- With CELL_CHAR_ACCUM_EN: two runs of count 10 each, second with accum=1 -> count=20; third with accum=0 -> count restarts from 0.

Source files
------------

// File: rtl/cell_char_pkg.sv
// Shared types, default sizing and saturating-increment helper for the
// standard-cell ring-oscillator characterization controller.
package cell_char_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } cc_state_t;

  localparam int N_CHAINS_DEF   = 4;
  localparam int SEL_W_DEF      = 2;
  localparam int CNT_W_DEF      = 16;
  localparam int WIN_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 8;

  // Returns {ovf, next}: next stays at max and ovf flags the lost increment.
  function automatic logic [32:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max);
    if (value >= max) return {1'b1, max};
    return {1'b0, value + 32'd1};
  endfunction

endpackage

// File: rtl/cell_char_sync.sv
// Two-flop synchronizer for the selected ring-oscillator tap plus a history
// flop; rise_pulse marks a synchronized 0->1 transition.
module cell_char_sync (
  input  logic CK,
  input  logic RST,
  input  logic din,
  output logic rise_pulse
);

  logic q1;
  logic q2;
  logic hist;

  always_ff @(posedge CK) begin
    if (RST) begin
      q1   <= 1'b0;
      q2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      q1   <= din;
      q2   <= q1;
      hist <= q2;
    end
  end

  assign rise_pulse = q2 & ~hist;

endmodule

// File: rtl/cell_char_ctrl.sv
// Ring-oscillator characterization controller: selects one chain, settles it,
// counts its edges over a gate window. Optional CELL_CHAR_ACCUM_EN adds accum.
//
//   state  | meaning
//   IDLE   | waiting for start; result registers hold
//   SETTLE | chain enabled, synchronizer filling, no counting
//   GATE   | chain enabled, synchronized rising edges counted
//   DONE   | one-cycle done pulse, chain disabled
module cell_char_ctrl
  import cell_char_pkg::*;
#(
  parameter int N_CHAINS   = N_CHAINS_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel,
  input  logic [WIN_W-1:0]    win_len,
`ifdef CELL_CHAR_ACCUM_EN
  input  logic                accum,
`endif
  input  logic [N_CHAINS-1:0] ro_in,
  output logic [N_CHAINS-1:0] ro_en,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                ovf,
  output logic                err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cc_state_t        state;
  cc_state_t        state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] tmr;
  logic             sel_bad;
  logic             keep_acc;
  logic             tmr_zero;
  logic             run;
  logic             ro_mux;
  logic             sync_in;
  logic             rise;
  logic [32:0]      inc_r;
  logic             unused_inc;

  assign sel_bad  = 32'(sel) >= 32'(N_CHAINS);
  assign tmr_zero = (tmr == '0);
  assign run      = (state == SETTLE) || (state == GATE);

`ifdef CELL_CHAR_ACCUM_EN
  assign keep_acc = accum;
`else
  assign keep_acc = 1'b0;
`endif

  // Only the latched tap is ever read, so unselected taps cannot leak X.
  always_comb begin
    ro_mux = 1'b0;
    for (int i = 0; i < N_CHAINS; i++) begin
      if (sel_q == SEL_W'(i)) ro_mux = ro_in[i];
    end
  end

  assign sync_in = run & ro_mux;

  cell_char_sync u_sync (
    .CK         (CK),
    .RST        (RST),
    .din        (sync_in),
    .rise_pulse (rise)
  );

  always_comb begin
    ro_en = '0;
    if (run) begin
      for (int i = 0; i < N_CHAINS; i++) begin
        ro_en[i] = (sel_q == SEL_W'(i));
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (sel_bad || (win_len == '0)) state_nxt = DONE;
          else                            state_nxt = SETTLE;
        end
      end
      SETTLE:  if (tmr_zero) state_nxt = GATE;
      GATE:    if (tmr_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign inc_r      = sat_inc(32'(count), 32'(CNT_MAX));
  assign unused_inc = &{1'b0, inc_r};

  always_ff @(posedge CK) begin
    if (RST) begin
      sel_q <= '0;
      win_q <= '0;
      tmr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_q <= sel;
            win_q <= win_len;
            tmr   <= WIN_W'(SETTLE_CYC - 1);
            err   <= sel_bad;
            if (!keep_acc) begin
              count <= '0;
              ovf   <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (tmr_zero) tmr <= win_q - WIN_W'(1);
          else          tmr <= tmr - WIN_W'(1);
        end
        GATE: begin
          tmr <= tmr - WIN_W'(1);
          if (rise) begin
            count <= inc_r[CNT_W-1:0];
            if (inc_r[32]) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_char_ctrl.sv
// Directed and randomized checks of cell_char_ctrl against a sample-based
// edge-count model; CELL_CHAR_ACCUM_EN enables the accumulate scenario.
module tb_cell_char_ctrl;

  localparam int S  = 8;
  localparam int NC = 4;

  logic        CK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  sel;
  logic [15:0] win_len;
  logic [3:0]  ro_in;
  logic [3:0]  ro_en;
  logic        busy, done, ovf, err;
  logic [15:0] count;

  logic        s_start;
  logic [1:0]  s_sel;
  logic [15:0] s_win;
  logic [3:0]  s_ro_en;
  logic        s_busy, s_done, s_ovf, s_err;
  logic [3:0]  s_count;
`ifdef CELL_CHAR_ACCUM_EN
  logic        accum;
  logic        s_accum;
`endif

  int   cyc = 0;
  int   half[NC]  = '{3, 5, 4, 2};
  int   phase[NC] = '{0, 1, 2, 0};
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_count = 0;
  logic m_ovf   = 1'b0;
  logic m_err   = 1'b0;
  int   sm_count;
  logic sm_ovf;

  cell_char_ctrl #(.N_CHAINS(4), .SEL_W(3), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut (
    .CK(CK), .RST(RST), .start(start), .sel(sel), .win_len(win_len),
`ifdef CELL_CHAR_ACCUM_EN
    .accum(accum),
`endif
    .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .done(done),
    .count(count), .ovf(ovf), .err(err)
  );

  cell_char_ctrl #(.N_CHAINS(4), .SEL_W(2), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) dut_sat (
    .CK(CK), .RST(RST), .start(s_start), .sel(s_sel), .win_len(s_win),
`ifdef CELL_CHAR_ACCUM_EN
    .accum(s_accum),
`endif
    .ro_in(ro_in), .ro_en(s_ro_en), .busy(s_busy), .done(s_done),
    .count(s_count), .ovf(s_ovf), .err(s_err)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Tap value sampled at the end of cycle n.
  function automatic logic ro_f(input int ch, input int n);
    return 1'(((n + phase[ch]) / half[ch]) % 2);
  endfunction

  always @(negedge CK) begin
    for (int i = 0; i < NC; i++) ro_in[i] = ro_f(i, cyc);
  end

  // Rising edges of the tap as seen through the two-sample synchronizer lag,
  // over the gate window of a run whose start cycle is t.
  function automatic int model_cnt(input int ch, input int t, input int w);
    int n = 0;
    for (int x = t + S + 1; x <= t + S + w; x++) begin
      if (ro_f(ch, x - 2) && !ro_f(ch, x - 3)) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_main(input int s, input int w, input logic acc);
    int t, len, raw;
    @(negedge CK);
    start = 1'b1; sel = 3'(s); win_len = 16'(w);
`ifdef CELL_CHAR_ACCUM_EN
    accum = acc;
`endif
    t   = cyc;
    len = (s < NC && w > 0) ? S + w : 0;
    raw = (len > 0) ? model_cnt(s, t, w) : 0;
    if (!acc) begin m_count = 0; m_ovf = 1'b0; end
    m_count += raw;
    if (m_count > 65535) begin m_count = 65535; m_ovf = 1'b1; end
    m_err = (s >= NC);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge CK);
      start = 1'b0;
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), (k == len + 1) ? 1 : 0);
      chk("ro_en", 32'(ro_en), (k <= len) ? (1 << s) : 0);
    end
    chk("count", 32'(count), m_count);
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("err", 32'(err), 32'(m_err));
    @(negedge CK);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("count_hold", 32'(count), m_count);
  endtask

  task automatic run_sat(input int s, input int w);
    int t, raw;
    @(negedge CK);
    s_start = 1'b1; s_sel = 2'(s); s_win = 16'(w);
    t        = cyc;
    raw      = model_cnt(s, t, w);
    sm_count = (raw > 15) ? 15 : raw;
    sm_ovf   = (raw > 15);
    for (int k = 1; k <= S + w + 1; k++) begin
      @(negedge CK);
      s_start = 1'b0;
      chk("sat_done", 32'(s_done), (k == S + w + 1) ? 1 : 0);
    end
    chk("sat_count", 32'(s_count), sm_count);
    chk("sat_ovf", 32'(s_ovf), 32'(sm_ovf));
  endtask

  initial begin
    int t, len, raw2, s, w;
    logic acc;
    RST = 1'b1; start = 1'b0; sel = '0; win_len = '0; ro_in = '0;
    s_start = 1'b0; s_sel = '0; s_win = '0;
`ifdef CELL_CHAR_ACCUM_EN
    accum = 1'b0; s_accum = 1'b0;
`endif
    repeat (3) @(negedge CK);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sat_count", 32'(s_count), 0);
    RST = 1'b0;

    // Period-8 tap on chain 2 over an 800-cycle window.
    half[2] = 4; phase[2] = 0;
    run_main(2, 800, 1'b0);
    chk("p8_range", 32'((count >= 16'd99) && (count <= 16'd101)), 1);

    run_main(0, 0, 1'b0);
    run_main(5, 10, 1'b0);

    // Saturation on a 4-bit counter, then a clean short run.
    half[3] = 2; phase[3] = 0;
    run_sat(3, 200);
    run_sat(3, 8);

    // Reset in the middle of GATE.
    @(negedge CK);
    start = 1'b1; sel = 3'd1; win_len = 16'd100;
    repeat (50) begin @(negedge CK); start = 1'b0; end
    chk("mid_busy", 32'(busy), 1);
    chk("mid_ro_en", 32'(ro_en), 2);
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    chk("abort_ro_en", 32'(ro_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_done", 32'(done), 0);
    m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 110; k++) begin
      @(negedge CK);
      chk("abort_no_done", 32'(done), 0);
    end

    // start held through a run, then a stray pulse while busy.
    @(negedge CK);
    start = 1'b1; sel = 3'd2; win_len = 16'd10;
    t    = cyc;
    len  = S + 10;
    raw2 = model_cnt(2, t + len + 2, 10);
    for (int k = 1; k <= 2 * len + 6; k++) begin
      @(negedge CK);
      if (k == len + 3) start = 1'b0;
      if (k == len + 6) start = 1'b1;
      if (k == len + 7) start = 1'b0;
      chk("b2b_done", 32'(done), (k == len + 1 || k == 2 * len + 3) ? 1 : 0);
      chk("b2b_busy", 32'(busy), (k == len + 2 || k > 2 * len + 3) ? 0 : 1);
    end
    chk("b2b_count", 32'(count), raw2);
    m_count = raw2; m_ovf = 1'b0; m_err = 1'b0;

    // Randomized runs, including out-of-range selects and empty windows.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NC; i++) begin
        half[i]  = int'($urandom_range(2, 7));
        phase[i] = int'($urandom_range(0, 15));
      end
      s = int'($urandom_range(0, 4));
      w = int'($urandom_range(0, 40));
`ifdef CELL_CHAR_ACCUM_EN
      acc = 1'($urandom_range(0, 1));
`else
      acc = 1'b0;
`endif
      run_main(s, w, acc);
    end

`ifdef CELL_CHAR_ACCUM_EN
    half[2] = 4; phase[2] = 0;
    run_main(2, 80, 1'b0);
    run_main(2, 80, 1'b1);
    run_main(2, 80, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
